// File: rtl/calc_scheduler_if.sv
// calc_scheduler_if: handshake bundle between request sources, the shared calc unit and the scheduler
//   efi_on      scheduler enable
//   req_inj     per-cylinder injection-calculation request pulses
//   req_ign     per-cylinder ignition-calculation request pulses
//   calc_done   completion pulse from the calc unit
//   calc_start  start pulse to the calc unit
//   calc_kind   0 = injection, 1 = ignition
//   calc_cyl    cylinder being calculated
//   busy        calculation launched and not yet finished
//   done        per-cylinder injection-result-ready pulse
//   btdc_ready  per-cylinder ignition-result-ready pulse
//   overrun     request absorbed by an already-pending bit
//   calc_error  calculation aborted on timeout
interface calc_scheduler_if #(
    parameter int CYLINDERS = 4
);
    localparam int CW = (CYLINDERS > 1) ? $clog2(CYLINDERS) : 1;

    logic                 efi_on;
    logic [CYLINDERS-1:0] req_inj;
    logic [CYLINDERS-1:0] req_ign;
    logic                 calc_done;
    logic                 calc_start;
    logic                 calc_kind;
    logic [CW-1:0]        calc_cyl;
    logic                 busy;
    logic [CYLINDERS-1:0] done;
    logic [CYLINDERS-1:0] btdc_ready;
    logic                 overrun;
    logic                 calc_error;

    modport master (
        output efi_on, req_inj, req_ign, calc_done,
        input  calc_start, calc_kind, calc_cyl, busy, done, btdc_ready, overrun, calc_error
    );

    modport slave (
        input  efi_on, req_inj, req_ign, calc_done,
        output calc_start, calc_kind, calc_cyl, busy, done, btdc_ready, overrun, calc_error
    );
endinterface

// File: rtl/calc_scheduler.sv
// calc_scheduler: shares one calculation unit among per-cylinder injection and ignition requests
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    calc_scheduler_if.slave: requests and calc_done in; calc_start, calc_kind, calc_cyl,
//          busy, done, btdc_ready, overrun, calc_error out
module calc_scheduler #(
    parameter int CYLINDERS      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input logic clk,
    input logic reset,
    calc_scheduler_if.slave bus
);
    localparam int CW = (CYLINDERS > 1) ? $clog2(CYLINDERS) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t               state, state_n;
    logic [CYLINDERS-1:0] pend_inj, pend_ign;
    logic [CYLINDERS-1:0] gnt_inj, gnt_ign;
    logic [CW-1:0]        ptr_inj, ptr_ign;
    logic [CW-1:0]        pick_inj, pick_ign;
    logic                 hit_inj, hit_ign;
    logic                 grant;
    logic [TW-1:0]        cnt;
    logic                 timeout;
    logic                 kind_q;
    logic [CW-1:0]        cyl_q;
    logic                 ovr_q;
    logic                 err_q;

    // {found, index}: first set bit of vec scanning upward from ptr with wraparound
    function automatic logic [CW:0] rr_pick(input logic [CYLINDERS-1:0] vec, input logic [CW-1:0] ptr);
        logic [CW:0]   r;
        logic [CW-1:0] idx;
        r = '0;
        for (int k = CYLINDERS - 1; k >= 0; k--) begin
            idx = CW'((int'(ptr) + k) % CYLINDERS);
            if (vec[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    function automatic logic [CW-1:0] next_idx(input logic [CW-1:0] i);
        return (i == CW'(CYLINDERS - 1)) ? '0 : i + 1'b1;
    endfunction

    // Ignition always outranks injection; each class has its own round-robin pointer.
    always_comb begin
        {hit_ign, pick_ign} = rr_pick(pend_ign, ptr_ign);
        {hit_inj, pick_inj} = rr_pick(pend_inj, ptr_inj);
        grant   = (state == IDLE) && bus.efi_on && (hit_ign || hit_inj);
        gnt_ign = (grant && hit_ign) ? CYLINDERS'(1) << pick_ign : '0;
        gnt_inj = (grant && !hit_ign) ? CYLINDERS'(1) << pick_inj : '0;
    end

    // Last WAIT cycle that may still see calc_done before the abort.
    assign timeout = cnt == TW'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = grant ? START : IDLE;
            START:   state_n = WAIT;
            WAIT:    state_n = bus.calc_done ? RESP : (timeout ? IDLE : WAIT);
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        bus.calc_start = state == START;
        bus.busy       = (state == START) || (state == WAIT);
        bus.calc_kind  = kind_q;
        bus.calc_cyl   = cyl_q;
        bus.done       = (state == RESP && !kind_q) ? CYLINDERS'(1) << cyl_q : '0;
        bus.btdc_ready = (state == RESP && kind_q) ? CYLINDERS'(1) << cyl_q : '0;
        bus.overrun    = ovr_q;
        bus.calc_error = err_q;
    end

    // A request landing on the bit being granted this cycle re-arms it rather than overrunning.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_inj <= '0;
            pend_ign <= '0;
            ptr_inj  <= '0;
            ptr_ign  <= '0;
            cnt      <= '0;
            kind_q   <= 1'b0;
            cyl_q    <= '0;
            ovr_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            pend_inj <= bus.efi_on ? (pend_inj & ~gnt_inj) | bus.req_inj : '0;
            pend_ign <= bus.efi_on ? (pend_ign & ~gnt_ign) | bus.req_ign : '0;
            ovr_q    <= |((bus.req_inj & pend_inj & ~gnt_inj) | (bus.req_ign & pend_ign & ~gnt_ign));
            err_q    <= (state == WAIT) && !bus.calc_done && timeout;
            cnt      <= (state == WAIT) ? cnt + 1'b1 : '0;
            if (grant) begin
                kind_q <= hit_ign;
                cyl_q  <= hit_ign ? pick_ign : pick_inj;
                if (hit_ign) ptr_ign <= next_idx(pick_ign);
                else         ptr_inj <= next_idx(pick_inj);
            end
        end
    end
endmodule

// File: tb/tb_calc_scheduler.sv
// tb_calc_scheduler: self-checking bench for calc_scheduler (CYLINDERS=4, TIMEOUT_CYCLES=16)
module tb_calc_scheduler;
    localparam int C = 4;
    localparam int T = 16;

    logic clk = 1'b0;
    logic reset;

    calc_scheduler_if #(.CYLINDERS(C)) bus ();

    calc_scheduler #(.CYLINDERS(C), .TIMEOUT_CYCLES(T)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model: pending flags per source, per-class pointers and a job phase
    // (0 nothing in flight, 1 launch cycle, 2 waiting for the unit, 3 result cycle).
    bit mp_inj[C];
    bit mp_ign[C];
    int m_ptr_inj, m_ptr_ign;
    int m_phase, m_waited, m_cyl;
    bit m_kind, m_ovr, m_err;

    typedef struct {
        bit           efi;
        logic [C-1:0] ri;
        logic [C-1:0] rg;
        bit           cd;
        logic [14:0]  exp;
    } vec_t;
    vec_t tbl[$];

    int order[$];
    int n_ovr, n_err;
    int n_done[C];
    int n_btdc[C];

    function automatic void m_reset();
        for (int i = 0; i < C; i++) begin
            mp_inj[i] = 0;
            mp_ign[i] = 0;
        end
        m_ptr_inj = 0; m_ptr_ign = 0; m_phase = 0; m_waited = 0;
        m_cyl = 0; m_kind = 0; m_ovr = 0; m_err = 0;
    endfunction

    function automatic void model_step(bit efi, logic [C-1:0] ri, logic [C-1:0] rg, bit cd);
        int gi;
        bit gk, ovr, gin, gig;
        gi = -1; gk = 0; ovr = 0;
        if (m_phase == 0 && efi) begin
            for (int k = 0; k < C && gi < 0; k++)
                if (mp_ign[(m_ptr_ign + k) % C]) begin gi = (m_ptr_ign + k) % C; gk = 1; end
            for (int k = 0; k < C && gi < 0; k++)
                if (mp_inj[(m_ptr_inj + k) % C]) gi = (m_ptr_inj + k) % C;
        end
        for (int i = 0; i < C; i++) begin
            gin = (gi == i) && !gk;
            gig = (gi == i) && gk;
            if ((ri[i] && mp_inj[i] && !gin) || (rg[i] && mp_ign[i] && !gig)) ovr = 1;
            mp_inj[i] = efi && ((mp_inj[i] && !gin) || ri[i]);
            mp_ign[i] = efi && ((mp_ign[i] && !gig) || rg[i]);
        end
        m_ovr = ovr;
        m_err = 0;
        if (m_phase == 0) begin
            if (gi >= 0) begin
                m_phase = 1; m_kind = gk; m_cyl = gi;
                if (gk) m_ptr_ign = (gi + 1) % C;
                else    m_ptr_inj = (gi + 1) % C;
            end
        end else if (m_phase == 1) begin
            m_phase = 2; m_waited = 0;
        end else if (m_phase == 2) begin
            if (cd) m_phase = 3;
            else begin
                m_waited++;
                if (m_waited == T) begin m_phase = 0; m_err = 1; end
            end
        end else m_phase = 0;
    endfunction

    function automatic logic [14:0] pk(bit st, bit kd, int cy, bit bz, logic [C-1:0] dn, logic [C-1:0] bt, bit ov, bit er);
        return {st, kd, 2'(cy), bz, dn, bt, ov, er};
    endfunction

    function automatic logic [14:0] model_out();
        logic [C-1:0] oh;
        oh = C'(1) << m_cyl;
        return pk(m_phase == 1, m_kind, m_cyl, m_phase == 1 || m_phase == 2,
                  oh & {C{m_phase == 3 && !m_kind}}, oh & {C{m_phase == 3 && m_kind}}, m_ovr, m_err);
    endfunction

    function automatic logic [14:0] actual();
        return {bus.calc_start, bus.calc_kind, bus.calc_cyl, bus.busy, bus.done, bus.btdc_ready, bus.overrun, bus.calc_error};
    endfunction

    task automatic check(input string name, input logic [14:0] act, input logic [14:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %b required %b (start kind cyl busy done btdc ovr err)", name, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic tally();
        if (bus.calc_start) order.push_back(int'(bus.calc_kind) * 8 + int'(bus.calc_cyl));
        n_ovr += int'(bus.overrun);
        n_err += int'(bus.calc_error);
        for (int i = 0; i < C; i++) begin
            n_done[i] += int'(bus.done[i]);
            n_btdc[i] += int'(bus.btdc_ready[i]);
        end
    endtask

    task automatic clear_tally();
        order.delete();
        n_ovr = 0; n_err = 0;
        for (int i = 0; i < C; i++) begin n_done[i] = 0; n_btdc[i] = 0; end
    endtask

    // Drive one cycle of inputs, clock it, then compare every output against the model.
    task automatic tick(input bit efi, input logic [C-1:0] ri, input logic [C-1:0] rg, input bit cd);
        bus.efi_on = efi; bus.req_inj = ri; bus.req_ign = rg; bus.calc_done = cd;
        @(posedge clk);
        model_step(efi, ri, rg, cd);
        #1;
        cyc++;
        check("model", actual(), model_out());
        tally();
    endtask

    // Idle inputs; when respond is set, calc_done is raised in every waiting cycle.
    task automatic serve(input int cycles, input bit efi, input bit respond);
        bit cd;
        cd = 0;
        repeat (cycles) begin
            tick(efi, '0, '0, cd);
            cd = respond && bus.busy && !bus.calc_start;
        end
    endtask

    task automatic do_reset();
        bus.efi_on = 1; bus.req_inj = '0; bus.req_ign = '0; bus.calc_done = 0;
        #2 reset = 1;
        m_reset();
        #4 reset = 0;
    endtask

    task automatic check_order(input string name, input int exp[$]);
        check_int({name, " grant count"}, order.size(), exp.size());
        for (int i = 0; i < exp.size() && i < order.size(); i++) check_int({name, " grant"}, order[i], exp[i]);
    endtask

    task automatic add(input bit efi, input logic [C-1:0] ri, input logic [C-1:0] rg, input bit cd, input logic [14:0] exp);
        vec_t v;
        v.efi = efi; v.ri = ri; v.rg = rg; v.cd = cd; v.exp = exp;
        tbl.push_back(v);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w, cd_div;
        logic [C-1:0] ri, rg;
        reset = 1;
        bus.efi_on = 1; bus.req_inj = '0; bus.req_ign = '0; bus.calc_done = 0;
        m_reset();
        clear_tally();
        #3;
        check("reset state", actual(), '0);
        #9 reset = 0;

        // single injection request, done three cycles after start
        add(1, 4'b0010, 4'b0000, 0, pk(0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0));
        add(1, 4'b0000, 4'b0000, 0, pk(1, 0, 1, 1, 4'b0000, 4'b0000, 0, 0));
        add(1, 4'b0000, 4'b0000, 0, pk(0, 0, 1, 1, 4'b0000, 4'b0000, 0, 0));
        add(1, 4'b0000, 4'b0000, 0, pk(0, 0, 1, 1, 4'b0000, 4'b0000, 0, 0));
        add(1, 4'b0000, 4'b0000, 0, pk(0, 0, 1, 1, 4'b0000, 4'b0000, 0, 0));
        add(1, 4'b0000, 4'b0000, 1, pk(0, 0, 1, 0, 4'b0010, 4'b0000, 0, 0));
        add(1, 4'b0000, 4'b0000, 0, pk(0, 0, 1, 0, 4'b0000, 4'b0000, 0, 0));
        // ignition request repeated in its own grant cycle re-arms without overrun; calc_done in START ignored
        add(1, 4'b0000, 4'b0001, 0, pk(0, 0, 1, 0, 4'b0000, 4'b0000, 0, 0));
        add(1, 4'b0000, 4'b0001, 0, pk(1, 1, 0, 1, 4'b0000, 4'b0000, 0, 0));
        add(1, 4'b0000, 4'b0000, 1, pk(0, 1, 0, 1, 4'b0000, 4'b0000, 0, 0));
        add(1, 4'b0000, 4'b0000, 1, pk(0, 1, 0, 0, 4'b0000, 4'b0001, 0, 0));
        add(1, 4'b0000, 4'b0000, 0, pk(0, 1, 0, 0, 4'b0000, 4'b0000, 0, 0));
        add(1, 4'b0000, 4'b0000, 0, pk(1, 1, 0, 1, 4'b0000, 4'b0000, 0, 0));
        add(1, 4'b0000, 4'b0000, 1, pk(0, 1, 0, 1, 4'b0000, 4'b0000, 0, 0));
        add(1, 4'b0000, 4'b0000, 1, pk(0, 1, 0, 0, 4'b0000, 4'b0001, 0, 0));
        add(1, 4'b0000, 4'b0000, 0, pk(0, 1, 0, 0, 4'b0000, 4'b0000, 0, 0));
        // injection cyl2: re-arm at grant, then a real overrun while pending
        add(1, 4'b0100, 4'b0000, 0, pk(0, 1, 0, 0, 4'b0000, 4'b0000, 0, 0));
        add(1, 4'b0100, 4'b0000, 0, pk(1, 0, 2, 1, 4'b0000, 4'b0000, 0, 0));
        add(1, 4'b0100, 4'b0000, 0, pk(0, 0, 2, 1, 4'b0000, 4'b0000, 1, 0));
        add(1, 4'b0000, 4'b0000, 1, pk(0, 0, 2, 0, 4'b0100, 4'b0000, 0, 0));
        add(1, 4'b0000, 4'b0000, 0, pk(0, 0, 2, 0, 4'b0000, 4'b0000, 0, 0));
        add(1, 4'b0000, 4'b0000, 0, pk(1, 0, 2, 1, 4'b0000, 4'b0000, 0, 0));
        add(1, 4'b0000, 4'b0000, 1, pk(0, 0, 2, 1, 4'b0000, 4'b0000, 0, 0));
        add(1, 4'b0000, 4'b0000, 1, pk(0, 0, 2, 0, 4'b0100, 4'b0000, 0, 0));
        add(1, 4'b0000, 4'b0000, 0, pk(0, 0, 2, 0, 4'b0000, 4'b0000, 0, 0));
        for (int i = 0; i < tbl.size(); i++) begin
            tick(tbl[i].efi, tbl[i].ri, tbl[i].rg, tbl[i].cd);
            check($sformatf("table row %0d", i), actual(), tbl[i].exp);
        end

        // ignition beats injection, then injection round-robin from 0
        do_reset();
        clear_tally();
        tick(1, 4'b1111, 4'b0100, 0);
        serve(40, 1, 1);
        check_order("mixed burst", '{10, 0, 1, 2, 3});
        check_int("mixed burst done pulses", n_done[0] + n_done[1] + n_done[2] + n_done[3], 4);
        check_int("mixed burst btdc[2] pulses", n_btdc[2], 1);
        check_int("mixed burst btdc total", n_btdc[0] + n_btdc[1] + n_btdc[2] + n_btdc[3], 1);

        // timeout after 16 waiting cycles, next pending request still served
        do_reset();
        clear_tally();
        tick(1, 4'b0011, 4'b0000, 0);
        tick(1, 4'b0000, 4'b0000, 0);
        check("timeout launch", {bus.calc_start, bus.calc_kind, bus.calc_cyl}, 15'({1'b1, 1'b0, 2'd0}));
        w = 0;
        for (int n = 0; n < 40 && !bus.calc_error; n++) begin
            tick(1, 4'b0000, 4'b0000, 0);
            if (bus.busy && !bus.calc_start) w++;
        end
        check_int("timeout error seen", int'(bus.calc_error), 1);
        check_int("timeout wait cycles", w, T);
        check_int("timeout no result", n_done[0] + n_btdc[0], 0);
        tick(1, 4'b0000, 4'b0000, 0);
        check("timeout next grant", {bus.calc_start, bus.calc_kind, bus.calc_cyl}, 15'({1'b1, 1'b0, 2'd1}));
        serve(10, 1, 1);
        check_int("timeout next done", n_done[1], 1);
        check_int("timeout error count", n_err, 1);

        // double ignition request while pending: one overrun, one grant
        do_reset();
        clear_tally();
        tick(1, 4'b0001, 4'b0000, 0);
        tick(1, 4'b0000, 4'b0000, 0);
        tick(1, 4'b0000, 4'b1000, 0);
        tick(1, 4'b0000, 4'b1000, 0);
        serve(20, 1, 1);
        check_int("overrun pulses", n_ovr, 1);
        check_order("overrun", '{0, 11});
        check_int("overrun btdc[3]", n_btdc[3], 1);

        // efi_on drop mid-calculation: result still delivered, pending request lost
        do_reset();
        clear_tally();
        tick(1, 4'b0001, 4'b0000, 0);
        tick(1, 4'b0000, 4'b0000, 0);
        tick(1, 4'b1000, 4'b0000, 0);
        tick(0, 4'b0000, 4'b0000, 0);
        tick(0, 4'b0000, 4'b0000, 1);
        serve(5, 0, 1);
        serve(20, 1, 1);
        check_int("efi drop in-flight done", n_done[0], 1);
        check_int("efi drop cyl3 done", n_done[3], 0);
        check_order("efi drop", '{0});

        // reset in the middle of a calculation
        do_reset();
        clear_tally();
        tick(1, 4'b0100, 4'b0000, 0);
        tick(1, 4'b0000, 4'b0000, 0);
        tick(1, 4'b0000, 4'b0000, 0);
        #2 reset = 1;
        m_reset();
        #1 check("async reset mid-wait", actual(), '0);
        #2 reset = 0;
        tick(1, 4'b0000, 4'b0000, 1);
        tick(1, 4'b0000, 4'b0000, 0);
        check_int("reset mid-wait results", n_done[2] + n_btdc[2] + n_err, 0);
        check_int("reset mid-wait busy", int'(bus.busy), 0);
        clear_tally();
        tick(1, 4'b1111, 4'b0000, 0);
        serve(25, 1, 1);
        check_order("pointer after reset", '{0, 1, 2, 3});

        // randomized traffic against the model
        do_reset();
        for (int b = 0; b < 16; b++) begin
            case ($urandom_range(0, 3))
                0:       cd_div = 0;
                1:       cd_div = 2;
                2:       cd_div = 5;
                default: cd_div = 60;
            endcase
            repeat (250) begin
                ri = ($urandom_range(0, 4) == 0) ? C'($urandom & $urandom) : '0;
                rg = ($urandom_range(0, 5) == 0) ? C'($urandom & $urandom) : '0;
                tick($urandom_range(0, 24) != 0, ri, rg, $urandom_range(0, cd_div) == 0);
            end
            if ($urandom_range(0, 3) == 0) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
